// File: rtl/pwm_compare_stage.sv
// PWM compare stage: compares an upstream modulo-PERIOD count against a double-buffered
// duty value and emits whole PWM periods only, with start/stop sequencing.
module pwm_compare_stage #(
  parameter int WIDTH  = 4,
  parameter int PERIOD = 16
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] CNT,
  input  logic [WIDTH:0]   DUTY,
  input  logic             DUTY_LD,
  output logic             DUTY_ACK,
  output logic             PWM,
  output logic             WRAP,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH:0]   DUTY_MAX = (WIDTH+1)'(PERIOD);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t         state_r;
  logic [WIDTH:0] duty_act_r;
  logic [WIDTH:0] duty_pend_r;
  logic           pend_r;

  logic           last_s;
  logic           emit_s;
  logic           xfer_s;
  logic [WIDTH:0] duty_clamp_s;

  function automatic logic [WIDTH:0] clamp_duty(input logic [WIDTH:0] d);
    logic [WIDTH:0] r;
    if (d > DUTY_MAX) begin
      r = DUTY_MAX;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Period boundary, emitting-state and duty transfer-point decode
  always_comb begin
    last_s       = (CNT == LAST_CNT);
    emit_s       = (state_r == S_RUN) || (state_r == S_DRAIN);
    xfer_s       = last_s || (state_r == S_OFF);
    duty_clamp_s = clamp_duty(DUTY);
  end

  // Start/stop sequencer; BUSY is registered alongside the state it describes
  always_ff @(posedge C) begin
    if (CLR) begin
      state_r <= S_OFF;
      BUSY    <= 1'b0;
    end else begin
      case (state_r)
        S_OFF: begin
          if (EN) begin
            state_r <= S_ARM;
            BUSY    <= 1'b1;
          end else begin
            state_r <= S_OFF;
            BUSY    <= 1'b0;
          end
        end
        S_ARM: begin
          if (last_s && EN) begin
            state_r <= S_RUN;
            BUSY    <= 1'b1;
          end else if (last_s) begin
            state_r <= S_OFF;
            BUSY    <= 1'b0;
          end else begin
            state_r <= S_ARM;
            BUSY    <= 1'b1;
          end
        end
        S_RUN: begin
          if (!EN) begin
            state_r <= S_DRAIN;
          end else begin
            state_r <= S_RUN;
          end
          BUSY <= 1'b1;
        end
        S_DRAIN: begin
          if (EN) begin
            state_r <= S_RUN;
            BUSY    <= 1'b1;
          end else if (last_s) begin
            state_r <= S_OFF;
            BUSY    <= 1'b0;
          end else begin
            state_r <= S_DRAIN;
            BUSY    <= 1'b1;
          end
        end
        default: begin
          state_r <= S_OFF;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

  // PWM and WRAP sample the pre-edge count, so they trail CNT by one cycle
  always_ff @(posedge C) begin
    if (CLR) begin
      PWM  <= 1'b0;
      WRAP <= 1'b0;
    end else begin
      PWM  <= emit_s && ({1'b0, CNT} < duty_act_r);
      WRAP <= emit_s && last_s;
    end
  end

  // Duty double buffer: a load at a transfer point goes straight to the active register
  always_ff @(posedge C) begin
    if (CLR) begin
      duty_act_r  <= '0;
      duty_pend_r <= '0;
      pend_r      <= 1'b0;
      DUTY_ACK    <= 1'b0;
    end else if (xfer_s && DUTY_LD) begin
      duty_act_r <= duty_clamp_s;
      pend_r     <= 1'b0;
      DUTY_ACK   <= 1'b1;
    end else if (xfer_s && pend_r) begin
      duty_act_r <= duty_pend_r;
      pend_r     <= 1'b0;
      DUTY_ACK   <= 1'b1;
    end else if (DUTY_LD) begin
      duty_pend_r <= duty_clamp_s;
      pend_r      <= 1'b1;
      DUTY_ACK    <= 1'b0;
    end else begin
      DUTY_ACK <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Bench for pwm_compare_stage: directed period-level checks followed by randomized stimulus
// compared every cycle against a behavioural model of the start/stop and duty rules.
module tb_pwm_compare_stage;

  localparam int WIDTH  = 4;
  localparam int PERIOD = 16;

  logic             c = 1'b0;
  logic             clr;
  logic             en;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0]   duty;
  logic             duty_ld;
  logic             duty_ack;
  logic             pwm;
  logic             wrap;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {M_OFF, M_ARM, M_RUN, M_DRAIN} mstate_t;
  mstate_t m_state = M_OFF;
  int      m_act   = 0;
  int      m_pend_val = 0;
  bit      m_pend  = 1'b0;

  pwm_compare_stage #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
    .C        (c),
    .CLR      (clr),
    .EN       (en),
    .CNT      (cnt),
    .DUTY     (duty),
    .DUTY_LD  (duty_ld),
    .DUTY_ACK (duty_ack),
    .PWM      (pwm),
    .WRAP     (wrap),
    .BUSY     (busy)
  );

  always #5 c = ~c;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cnt=%0d, t=%0t)", tag, got, want, cnt, $time);
    end
  endtask

  // One clock: predict from the current inputs, clock, compare, then advance the counter.
  task automatic step();
    bit exp_pwm, exp_wrap, exp_ack, exp_busy, last, emitting;
    int d;
    if (clr) begin
      m_state = M_OFF; m_act = 0; m_pend = 1'b0; m_pend_val = 0;
      exp_pwm = 1'b0; exp_wrap = 1'b0; exp_ack = 1'b0; exp_busy = 1'b0;
    end else begin
      last     = (int'(cnt) == PERIOD - 1);
      emitting = (m_state == M_RUN) || (m_state == M_DRAIN);
      exp_pwm  = emitting && (int'(cnt) < m_act);
      exp_wrap = emitting && last;
      d        = (int'(duty) > PERIOD) ? PERIOD : int'(duty);
      exp_ack  = 1'b0;
      if (last || m_state == M_OFF) begin
        if (duty_ld) begin
          m_act = d; m_pend = 1'b0; exp_ack = 1'b1;
        end else if (m_pend) begin
          m_act = m_pend_val; m_pend = 1'b0; exp_ack = 1'b1;
        end
      end else if (duty_ld) begin
        m_pend_val = d; m_pend = 1'b1;
      end
      case (m_state)
        M_OFF:   if (en) m_state = M_ARM;
        M_ARM:   if (last) m_state = en ? M_RUN : M_OFF;
        M_RUN:   if (!en) m_state = M_DRAIN;
        M_DRAIN: if (en) m_state = M_RUN; else if (last) m_state = M_OFF;
        default: m_state = M_OFF;
      endcase
      exp_busy = (m_state != M_OFF);
    end
    @(posedge c);
    #1;
    check_eq("pwm", int'(pwm), int'(exp_pwm));
    check_eq("wrap", int'(wrap), int'(exp_wrap));
    check_eq("duty_ack", int'(duty_ack), int'(exp_ack));
    check_eq("busy", int'(busy), int'(exp_busy));
    if (clr || int'(cnt) == PERIOD - 1) cnt = '0;
    else cnt = cnt + WIDTH'(1);
  endtask

  task automatic step_until_cnt(input int target);
    for (int i = 0; i < PERIOD && int'(cnt) != target; i++) step();
  endtask

  // Runs one period starting at cnt==0 and tallies PWM-high cycles and WRAP pulses.
  task automatic run_period(output int highs, output int wraps);
    highs = 0;
    wraps = 0;
    for (int i = 0; i < PERIOD; i++) begin
      step();
      highs += int'(pwm);
      wraps += int'(wrap);
    end
  endtask

  initial begin
    int highs, wraps;
    clr = 1'b1; en = 1'b0; duty_ld = 1'b0; duty = '0; cnt = '0;
    step();
    step();
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_pwm", int'(pwm), 0);
    clr = 1'b0;

    // Start at CNT=5 with duty 4: immediate ACK, first period 4 high
    step_until_cnt(5);
    duty = 5'd4; duty_ld = 1'b1; en = 1'b1;
    step();
    duty_ld = 1'b0;
    check_eq("t1_ack", int'(duty_ack), 1);
    step_until_cnt(0);
    check_eq("t1_busy_run", int'(busy), 1);
    run_period(highs, wraps);
    check_eq("t1_highs", highs, 4);
    check_eq("t1_wraps", wraps, 1);

    // Mid-period load of 10 takes effect on the next period only
    step_until_cnt(7);
    duty = 5'd10; duty_ld = 1'b1;
    step();
    duty_ld = 1'b0;
    step_until_cnt(0);
    run_period(highs, wraps);
    check_eq("t2_highs", highs, 10);

    // Clamp of 31 to full duty, then duty 0
    step_until_cnt(3);
    duty = 5'd31; duty_ld = 1'b1;
    step();
    duty_ld = 1'b0;
    step_until_cnt(0);
    run_period(highs, wraps);
    check_eq("t3_highs_full", highs, 16);
    check_eq("t3_wraps_full", wraps, 1);
    step_until_cnt(15);
    duty = 5'd0; duty_ld = 1'b1;
    step();
    duty_ld = 1'b0;
    check_eq("t5_ack", int'(duty_ack), 1);
    duty = 5'd16;
    run_period(highs, wraps);
    check_eq("t3_highs_zero", highs, 0);
    check_eq("t3_wraps_zero", wraps, 1);

    // Stop at CNT=9: drains the period, then idle
    step_until_cnt(9);
    en = 1'b0;
    step_until_cnt(0);
    step();
    check_eq("t4_busy_off", int'(busy), 0);
    run_period(highs, wraps);
    check_eq("t4_highs_idle", highs, 0);
    check_eq("t4_wraps_idle", wraps, 0);

    // Randomized phase, checked every cycle against the model
    for (int n = 0; n < 3000; n++) begin
      clr     = ($urandom_range(0, 199) == 0);
      duty_ld = ($urandom_range(0, 9) == 0);
      duty    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 29) == 0) en = ~en;
      if (!en && $urandom_range(0, 39) == 0) begin
        en = 1'b1;
        step();
        en = 1'b0;
        duty_ld = 1'b0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
